// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Resolution-side partner of the tournament branch predictor.
//               Queues one prediction record per in-flight predicted branch,
//               compares it with the MEM-stage outcome, drives the predictor
//               update strobe and, on a mispredict, redirect/flush.
//               Optional statistics counters: BRANCH_RESOLVE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    output logic        pred_ready,
    input  logic [31:0] pred_pc,
    input  logic        pred_take,
    input  logic [2:0]  pred_lgp,
    input  logic [31:0] pred_target,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        update_history,
    output logic        br_result,
    output logic [31:0] mem_pc,
    output logic [31:0] target_addr_in,
    output logic        old_l,
    output logic        old_g,
    output logic        old_p,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        desync_err
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_total,
    output logic [31:0] stat_mispred
`endif
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;

    // Record storage (no reset needed: validity is tracked by r_count)
    logic [31:0]        r_pc_mem   [DEPTH];
    logic [31:0]        r_tgt_mem  [DEPTH];
    logic               r_take_mem [DEPTH];
    logic [2:0]         r_lgp_mem  [DEPTH];

    logic               w_run;
    logic               w_push;
    logic               w_pop;
    logic               w_match;
    logic               w_mispred;
    logic               w_flush_q;
    logic [31:0]        w_h_pc;
    logic [31:0]        w_h_tgt;
    logic               w_h_take;
    logic [2:0]         w_h_lgp;
    logic [31:0]        w_redirect_pc;

    assign w_run      = (r_state == ST_RUN);
    assign res_ready  = w_run && (r_count != '0);
    assign w_pop      = res_valid && res_ready;
    // A full queue still accepts a record when the head retires this cycle
    assign pred_ready = w_run && ((r_count < (PTR_W+1)'(DEPTH)) || w_pop);
    assign w_push     = pred_valid && pred_ready;

    assign w_h_pc   = r_pc_mem[r_rd_ptr];
    assign w_h_tgt  = r_tgt_mem[r_rd_ptr];
    assign w_h_take = r_take_mem[r_rd_ptr];
    assign w_h_lgp  = r_lgp_mem[r_rd_ptr];

    // Target only matters when the branch was actually taken
    assign w_match   = (res_pc == w_h_pc);
    assign w_mispred = !w_match || (w_h_take != res_taken) ||
                       (res_taken && (w_h_tgt != res_target));
    // A mispredicting pop empties the queue and swallows any same-cycle push
    assign w_flush_q = w_pop && w_mispred;

    assign w_redirect_pc = res_taken ? res_target : (res_pc + 32'd4);

    // Queue pointers, occupancy and RUN/RECOVER sequencing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush_q) begin
            r_state  <= ST_RECOVER;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= ST_RUN;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Record write on an accepted, non-dropped push
    always_ff @(posedge clk) begin
        if (w_push && !w_flush_q) begin
            r_pc_mem[r_wr_ptr]   <= pred_pc;
            r_tgt_mem[r_wr_ptr]  <= pred_target;
            r_take_mem[r_wr_ptr] <= pred_take;
            r_lgp_mem[r_wr_ptr]  <= pred_lgp;
        end
    end

    // Registered predictor-update, redirect and desync outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_history <= 1'b0;
            br_result      <= 1'b0;
            mem_pc         <= '0;
            target_addr_in <= '0;
            old_l          <= 1'b0;
            old_g          <= 1'b0;
            old_p          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            desync_err     <= 1'b0;
        end else begin
            update_history <= w_pop && w_match;
            redirect_valid <= w_flush_q;
            flush          <= w_flush_q;
            if (w_pop) begin
                br_result      <= res_taken;
                mem_pc         <= res_pc;
                target_addr_in <= res_target;
                {old_l, old_g, old_p} <= w_h_lgp;
            end
            if (w_flush_q) begin
                redirect_pc <= w_redirect_pc;
            end
            if (w_pop && !w_match) begin
                desync_err <= 1'b1;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    // Saturating resolution statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_total   <= '0;
            stat_mispred <= '0;
        end else begin
            if (w_pop && w_match && (stat_total != 32'hFFFF_FFFF)) begin
                stat_total <= stat_total + 32'd1;
            end
            if (w_flush_q && (stat_mispred != 32'hFFFF_FFFF)) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve
// Description : Self-checking bench for branch_resolve: table-driven cycle
//               vectors with a reference FIFO model feeding a scoreboard of
//               next-cycle outputs, plus a hand-written reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic        pred_ready;
    logic [31:0] pred_pc;
    logic        pred_take;
    logic [2:0]  pred_lgp;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        update_history;
    logic        br_result;
    logic [31:0] mem_pc;
    logic [31:0] target_addr_in;
    logic        old_l;
    logic        old_g;
    logic        old_p;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        desync_err;

    branch_resolve #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_take(pred_take), .pred_lgp(pred_lgp), .pred_target(pred_target),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target),
        .update_history(update_history), .br_result(br_result), .mem_pc(mem_pc),
        .target_addr_in(target_addr_in), .old_l(old_l), .old_g(old_g), .old_p(old_p),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .desync_err(desync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        ptake;
        logic [2:0]  plgp;
        logic [31:0] ptgt;
        logic        rv;
        logic [31:0] rpc;
        logic        rtaken;
        logic [31:0] rtgt;
        logic        e_pr;
        logic        e_rr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        take;
        logic [2:0]  lgp;
        logic [31:0] tgt;
    } rec_t;

    typedef struct {
        logic        upd;
        logic        br;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [2:0]  lgp;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    vec_t vecs[$];
    rec_t m_fifo[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic m_desync = 1'b0;
    logic popped_last = 1'b0;

    function automatic vec_t mk(logic pv, logic [31:0] ppc, logic ptake, logic [2:0] plgp,
                                logic [31:0] ptgt, logic rv, logic [31:0] rpc, logic rtaken,
                                logic [31:0] rtgt, logic epr, logic err);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.ptake = ptake; v.plgp = plgp; v.ptgt = ptgt;
        v.rv = rv; v.rpc = rpc; v.rtaken = rtaken; v.rtgt = rtgt;
        v.e_pr = epr; v.e_rr = err;
        return v;
    endfunction

    function automatic vec_t mk_push(logic [31:0] pc, logic take, logic [2:0] lgp,
                                     logic [31:0] tgt, logic epr, logic err);
        return mk(1'b1, pc, take, lgp, tgt, 1'b0, 32'h0, 1'b0, 32'h0, epr, err);
    endfunction

    function automatic vec_t mk_res(logic [31:0] pc, logic taken, logic [31:0] tgt,
                                    logic epr, logic err);
        return mk(1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1, pc, taken, tgt, epr, err);
    endfunction

    function automatic vec_t mk_idle(logic epr, logic err);
        return mk(1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, epr, err);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare registered outputs produced by the edge just passed
    task automatic check_outputs();
        exp_t e;
        if (popped_last) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                chk1("update_history", update_history, e.upd);
                chk1("redirect_valid", redirect_valid, e.redir);
                chk1("flush", flush, e.redir);
                if (e.upd) begin
                    chk1("br_result", br_result, e.br);
                    chk32("mem_pc", mem_pc, e.pc);
                    chk32("target_addr_in", target_addr_in, e.tgt);
                    chk32("old_lgp", {29'h0, old_l, old_g, old_p}, {29'h0, e.lgp});
                end
                if (e.redir) begin
                    chk32("redirect_pc", redirect_pc, e.rpc);
                end
            end
        end else begin
            chk1("update_history_idle", update_history, 1'b0);
            chk1("redirect_valid_idle", redirect_valid, 1'b0);
            chk1("flush_idle", flush, 1'b0);
        end
        chk1("desync_err", desync_err, m_desync);
        popped_last = 1'b0;
    endtask

    // Drive one cycle from a vector, check handshakes, advance the model
    task automatic apply(input vec_t v);
        rec_t h;
        rec_t r;
        exp_t e;
        logic push_f;
        logic pop_f;
        logic match;
        logic mis;
        check_outputs();
        pred_valid = v.pv; pred_pc = v.ppc; pred_take = v.ptake;
        pred_lgp = v.plgp; pred_target = v.ptgt;
        res_valid = v.rv; res_pc = v.rpc; res_taken = v.rtaken; res_target = v.rtgt;
        #1;
        chk1("pred_ready", pred_ready, v.e_pr);
        chk1("res_ready", res_ready, v.e_rr);
        push_f = v.pv && v.e_pr;
        pop_f  = v.rv && v.e_rr;
        if (pop_f) begin
            if (m_fifo.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL model_fifo: got empty expected a head record");
            end else begin
                h = m_fifo.pop_front();
                match = (v.rpc == h.pc);
                mis = !match || (h.take != v.rtaken) || (v.rtaken && (h.tgt != v.rtgt));
                e.upd = match; e.br = v.rtaken; e.pc = v.rpc; e.tgt = v.rtgt;
                e.lgp = h.lgp; e.redir = mis;
                e.rpc = v.rtaken ? v.rtgt : v.rpc + 32'd4;
                sb.push_back(e);
                popped_last = 1'b1;
                if (!match) m_desync = 1'b1;
                if (mis) begin
                    m_fifo.delete();
                    push_f = 1'b0;
                end
            end
        end
        if (push_f) begin
            r.pc = v.ppc; r.take = v.ptake; r.lgp = v.plgp; r.tgt = v.ptgt;
            m_fifo.push_back(r);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        pred_valid = 1'b0; pred_pc = '0; pred_take = 1'b0; pred_lgp = '0; pred_target = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;

        // Vector table: one entry per cycle
        vecs.push_back(mk_idle(1'b1, 1'b0));
        // correct taken branch
        vecs.push_back(mk_push(32'h100, 1'b1, 3'b101, 32'h200, 1'b1, 1'b0));
        vecs.push_back(mk_res (32'h100, 1'b1, 32'h200, 1'b1, 1'b1));
        vecs.push_back(mk_idle(1'b1, 1'b0));
        // direction mispredict, push attempt during RECOVER
        vecs.push_back(mk_push(32'h40, 1'b1, 3'b010, 32'h80, 1'b1, 1'b0));
        vecs.push_back(mk_res (32'h40, 1'b0, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_push(32'h999, 1'b1, 3'b111, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk_idle(1'b1, 1'b0));
        // target mispredict
        vecs.push_back(mk_push(32'h60, 1'b1, 3'b111, 32'h300, 1'b1, 1'b0));
        vecs.push_back(mk_res (32'h60, 1'b1, 32'h380, 1'b1, 1'b1));
        vecs.push_back(mk_idle(1'b0, 1'b0));
        // full queue, simultaneous push/pop, wrap and back-to-back updates
        vecs.push_back(mk_push(32'h1000, 1'b0, 3'b001, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk_push(32'h1004, 1'b0, 3'b010, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_push(32'h1008, 1'b0, 3'b011, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_push(32'h100C, 1'b0, 3'b110, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_push(32'h1010, 1'b0, 3'b100, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 32'h1010, 1'b0, 3'b100, 32'h0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_res (32'h1004, 1'b0, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_res (32'h1008, 1'b0, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_res (32'h100C, 1'b0, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_res (32'h1010, 1'b0, 32'h0, 1'b1, 1'b1));
        // desync with same-cycle push dropped
        vecs.push_back(mk_push(32'h104, 1'b1, 3'b001, 32'h200, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 32'h700, 1'b1, 3'b000, 32'h710, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b1));
        vecs.push_back(mk_idle(1'b0, 1'b0));
        vecs.push_back(mk_idle(1'b1, 1'b0));
        // correct not-taken branch while desync stays sticky
        vecs.push_back(mk_push(32'h800, 1'b0, 3'b110, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk_res (32'h800, 1'b0, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk_idle(1'b1, 1'b0));
        // fall-through redirect wraps past 2^32
        vecs.push_back(mk_push(32'hFFFF_FFFC, 1'b1, 3'b000, 32'h10, 1'b1, 1'b0));
        vecs.push_back(mk_res (32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 1'b1));
        vecs.push_back(mk_idle(1'b0, 1'b0));
        vecs.push_back(mk_idle(1'b1, 1'b0));

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_update_history", update_history, 1'b0);
        chk1("rst_redirect_valid", redirect_valid, 1'b0);
        chk1("rst_flush", flush, 1'b0);
        chk32("rst_mem_pc", mem_pc, 32'h0);
        chk32("rst_redirect_pc", redirect_pc, 32'h0);
        chk1("rst_desync_err", desync_err, 1'b0);
        chk1("rst_res_ready", res_ready, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Reset mid-stream with three records queued and a strobe pending
        apply(mk_push(32'h2000, 1'b0, 3'b011, 32'h0, 1'b1, 1'b0));
        apply(mk_push(32'h2004, 1'b0, 3'b011, 32'h0, 1'b1, 1'b1));
        apply(mk_push(32'h2008, 1'b0, 3'b011, 32'h0, 1'b1, 1'b1));
        apply(mk(1'b1, 32'h200C, 1'b0, 3'b011, 32'h0, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b1));
        chk1("pending_strobe", update_history, 1'b1);
        chk1("pending_desync", desync_err, 1'b1);
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        rst = 1'b0;
        #1;
        chk1("midrst_update_history", update_history, 1'b0);
        chk1("midrst_desync_err", desync_err, 1'b0);
        chk32("midrst_mem_pc", mem_pc, 32'h0);
        chk32("midrst_old_lgp", {29'h0, old_l, old_g, old_p}, 32'h0);
        chk1("midrst_br_result", br_result, 1'b0);
        chk1("midrst_res_ready", res_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        res_valid = 1'b1;
        res_pc = 32'h2004;
        #1;
        chk1("postrst_res_ready", res_ready, 1'b0);
        @(negedge clk);
        chk1("postrst_update_history", update_history, 1'b0);
        chk1("postrst_desync_err", desync_err, 1'b0);
        res_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
